// File: rtl/program_counter.sv
// Program counter: WIDTH-bit address register built from d_ff cells, with
// mux2-tree next-address selection (increment / jump / relative branch /
// hold), gate-level ripple arithmetic, and a RUN/HALT control machine.

// Storage cell: rising-edge register with asynchronous active-high reset.
module d_ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Load d each edge; reset value is forced asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end
endmodule

// Two-input selector: y = sel ? b : a.
module mux2 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// Ripple-carry adder from full-adder gate cells.
module ripple_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  wire [W:0]   c;
  wire [W-1:0] s;
  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    wire p, g, t;
    xor (p, a[i], b[i]);
    xor (s[i], p, c[i]);
    and (g, a[i], b[i]);
    and (t, p, c[i]);
    or  (c[i+1], g, t);
  end

  assign sum  = s;
  assign cout = c[W];
endmodule

// Ripple incrementer (a + 1) from half-adder gate cells.
module ripple_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum,
  output logic         cout
);
  wire [W:0]   c;
  wire [W-1:0] s;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_ha
    xor (s[i], a[i], c[i]);
    and (c[i+1], a[i], c[i]);
  end

  assign sum  = s;
  assign cout = c[W];
endmodule

module program_counter #(
  parameter int          WIDTH        = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             JUMP,
  input  logic [WIDTH-1:0] JUMP_ADDR,
  input  logic             BRANCH,
  input  logic [WIDTH-1:0] BR_OFFSET,
  input  logic             HALT,
  input  logic             RESUME,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             WRAPPED,
  output logic             HALTED
);
  localparam logic [WIDTH-1:0] RV = RESET_VECTOR[WIDTH-1:0];

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             state_q;
  logic             advance;
  logic [WIDTH-1:0] inc_sum, br_sum, seq_addr, tgt_addr, upd_addr;
  logic             inc_co, br_co, br_wrap, sel_wrap, wrap_nxt;

  // State bit lives in a d_ff cell; RUN is the reset state.
  d_ff #(.W(1), .RST_VAL(1'b0)) u_state (
    .clk(CLK), .rst(RST), .d(state_nxt), .q(state_q)
  );
  assign state  = state_t'(state_q);
  assign HALTED = (state == S_HALT);

  // Next state and advance qualifier; HALT is checked ahead of EN.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      S_RUN: begin
        if (HALT)    state_nxt = S_HALT;
        else if (EN) advance   = 1'b1;
      end
      S_HALT: begin
        if (RESUME && !HALT) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  ripple_inc #(.W(WIDTH)) u_inc (.a(PC), .sum(inc_sum), .cout(inc_co));
  ripple_add #(.W(WIDTH)) u_add (
    .a(PC), .b(BR_OFFSET), .cin(1'b0), .sum(br_sum), .cout(br_co)
  );

  // Next-address tree: branch over increment, jump over both, hold when
  // not advancing, reset vector while RST is high.
  mux2 #(.W(WIDTH)) u_m_br  (.sel(BRANCH),  .a(inc_sum),  .b(br_sum),    .y(seq_addr));
  mux2 #(.W(WIDTH)) u_m_jmp (.sel(JUMP),    .a(seq_addr), .b(JUMP_ADDR), .y(tgt_addr));
  mux2 #(.W(WIDTH)) u_m_adv (.sel(advance), .a(PC),       .b(tgt_addr),  .y(upd_addr));
  mux2 #(.W(WIDTH)) u_m_rst (.sel(RST),     .a(upd_addr), .b(RV),        .y(PC_NEXT));

  d_ff #(.W(WIDTH), .RST_VAL(RV)) u_pc (
    .clk(CLK), .rst(RST), .d(PC_NEXT), .q(PC)
  );

  // Adding a negative offset wraps when there is no carry-out (a borrow);
  // a non-negative offset wraps on carry-out. Hence carry XOR sign.
  assign br_wrap = br_co ^ BR_OFFSET[WIDTH-1];
  mux2 #(.W(1)) u_m_wrap (.sel(BRANCH), .a(inc_co), .b(br_wrap), .y(sel_wrap));
  assign wrap_nxt = advance & ~JUMP & sel_wrap;

  d_ff #(.W(1), .RST_VAL(1'b0)) u_wrap (
    .clk(CLK), .rst(RST), .d(wrap_nxt), .q(WRAPPED)
  );
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Holds the current instruction address for the CPU core; sits directly downstream of the flip-flop primitive and is built as a WIDTH-bit bank of d_ff cells plus next-address logic.
- Selects the next PC each cycle: sequential increment, absolute jump, signed relative branch, or hold.
- Drives the instruction-fetch address and provides a small RUN/HALT state machine for stall and halt control.

Parameters:
- WIDTH, 8, address width in bits (2..16).
- RESET_VECTOR, 0, PC value after reset; must fit in WIDTH bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  advance enable; 0 = stall (PC holds).
- JUMP  input  1  absolute jump request.
- JUMP_ADDR  input  WIDTH  jump target.
- BRANCH  input  1  relative branch request.
- BR_OFFSET  input  WIDTH  two's-complement branch offset, relative to current PC.
- HALT  input  1  halt request.
- RESUME  input  1  leave HALT state.
- PC  output  WIDTH  current address (registered).
- PC_NEXT  output  WIDTH  address that will load on the next enabled edge (combinational).
- WRAPPED  output  1  registered 1-cycle pulse: the last update wrapped past the top or bottom of the address space.
- HALTED  output  1  1 while in HALT state.

Behaviour:
- Reset: RST=1 forces PC=RESET_VECTOR, WRAPPED=0, HALTED=0 and state=RUN immediately, independent of CLK. Reset overrides every other input, including mid-cycle assertion. The first update happens on the first rising edge after RST falls.
- States: RUN, HALT.
  - RUN -> HALT: on an edge with HALT=1. HALT is checked before EN, so a halt request is honoured even while stalled.
  - HALT -> RUN: on an edge with RESUME=1 and HALT=0. If HALT and RESUME are both 1, the block stays in HALT.
  - In HALT, PC holds and JUMP, BRANCH and EN are ignored.
- Next-address priority, in RUN with EN=1 and HALT=0:
  1. JUMP: PC <= JUMP_ADDR.
  2. BRANCH: PC <= PC + BR_OFFSET, modulo 2^WIDTH.
  3. Otherwise: PC <= PC + 1, modulo 2^WIDTH.
  - JUMP and BRANCH asserted together: JUMP wins.
- Hold conditions: EN=0 in RUN, the RUN->HALT edge itself, and all of HALT. PC is unchanged and WRAPPED is 0 on those edges.
- PC_NEXT: always equals the value PC would take on the next edge under the current inputs and state. In hold cases it equals PC. While RST=1 it equals RESET_VECTOR.
- WRAPPED: set for exactly one cycle when the edge that updated PC meets one of these conditions:
  - increment from all-ones to 0;
  - branch with carry-out, for non-negative offsets;
  - branch with borrow, for negative offsets.
  - Jumps never set WRAPPED.
- Latency: a request sampled at edge N is visible on PC after edge N with no extra pipeline stage. PC_NEXT has zero latency.
- Width rule: all arithmetic is WIDTH bits. BR_OFFSET is sign-interpreted by its MSB; no sign extension is required.
- Structure: PC, WRAPPED and the state bit are stored in d_ff instances. Next-state selection uses mux2 trees. The incrementer and adder are a ripple structure built from gate primitives.

Test Plan:
- Reset and count: WIDTH=8, RESET_VECTOR=0x10. Assert RST, then release with EN=1 for 3 edges -> PC = 0x10, 0x11, 0x12, 0x13; WRAPPED=0 throughout.
- Wrap on increment: jump to 0xFF, then 1 increment edge -> PC=0x00 with WRAPPED=1 for one cycle. Next edge -> PC=0x01, WRAPPED=0.
- Branch and priority:
  - PC=0x05, BRANCH=1, BR_OFFSET=0xFE (-2) -> PC=0x03, no wrap.
  - PC=0x01, BR_OFFSET=0xFD -> PC=0xFE with WRAPPED=1.
  - JUMP=1 (JUMP_ADDR=0x40) and BRANCH=1 together -> PC=0x40.
- Stall and halt:
  - EN=0 for 4 edges -> PC constant, PC_NEXT=PC.
  - HALT=1 for one edge, then JUMP=1 -> PC unchanged, HALTED=1.
  - HALT=1 and RESUME=1 together -> stays halted.
  - RESUME alone -> HALTED=0 and increments resume on the following edge.
- Async reset mid-operation: PC=0x37 in RUN; pulse RST between clock edges -> PC=0x10 and HALTED=0 before the next rising edge. Repeat from HALT -> same result.
